// File: rtl/traffic_monitor.sv
// Conflict/sequence monitor for the four traffic light buses.
// Latches the first violation as a sticky fault with code and direction.
module traffic_monitor #(
    parameter int MIN_GREEN  = 3,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_ALLRED = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] north,
    input  logic [2:0] south,
    input  logic [2:0] east,
    input  logic [2:0] west,
    input  logic       clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic [1:0] active_dir,
    output logic       active_valid,
    output logic [7:0] phase_cnt
);

    typedef enum logic [2:0] {
        RED    = 3'b100,
        YELLOW = 3'b010,
        GREEN  = 3'b001
    } colour_t;

    colour_t          prev_q  [4];
    colour_t          prev_d  [4];
    logic [CNT_W-1:0] dwell_q [4];
    logic [CNT_W-1:0] dwell_d [4];
    logic [CNT_W-1:0] allred_q, allred_d;

    logic [2:0] bus   [4];
    logic [2:0] dcode [4];
    logic [2:0] nonred_cnt, yr_cnt;
    logic       all_legal, all_red, ar_fault;
    logic [1:0] act_idx;
    logic [2:0] vcode;
    logic [1:0] vdir;
    logic       valid_d;
    logic [1:0] active_dir_d;
    logic [7:0] phase_d;

    always_comb begin
        bus[0] = north;
        bus[1] = south;
        bus[2] = east;
        bus[3] = west;
    end

    always_comb begin
        nonred_cnt = '0;
        yr_cnt     = '0;
        all_legal  = 1'b1;
        all_red    = 1'b1;
        act_idx    = active_dir;
        for (int unsigned d = 0; d < 4; d++) begin
            dcode[d]   = '0;
            prev_d[d]  = prev_q[d];
            dwell_d[d] = dwell_q[d];
            if (!(bus[d] == RED || bus[d] == YELLOW || bus[d] == GREEN)) begin
                // illegal bus: leave its tracking untouched and skip conflict check
                dcode[d]  = 3'd1;
                all_legal = 1'b0;
                all_red   = 1'b0;
            end else begin
                if (bus[d] != RED) begin
                    nonred_cnt = nonred_cnt + 3'd1;
                    act_idx    = 2'(d);
                    all_red    = 1'b0;
                end
                if (bus[d] == prev_q[d]) begin
                    if (dwell_q[d] != '1)
                        dwell_d[d] = dwell_q[d] + 1'b1;
                end else begin
                    dwell_d[d] = CNT_W'(1);
                    prev_d[d]  = colour_t'(bus[d]);
                    case (prev_q[d])
                        RED:    if (bus[d] != GREEN) dcode[d] = 3'd3;
                        GREEN: begin
                            if (bus[d] != YELLOW)
                                dcode[d] = 3'd3;
                            else if (dwell_q[d] != '1 && int'(dwell_q[d]) < MIN_GREEN)
                                dcode[d] = 3'd4;
                        end
                        YELLOW: begin
                            if (bus[d] != RED) begin
                                dcode[d] = 3'd3;
                            end else begin
                                yr_cnt = yr_cnt + 3'd1;
                                if (dwell_q[d] != '1 && int'(dwell_q[d]) < MIN_YELLOW)
                                    dcode[d] = 3'd5;
                            end
                        end
                        default: dcode[d] = 3'd3;
                    endcase
                end
            end
        end

        if (!all_red)
            allred_d = '0;
        else if (allred_q == '1)
            allred_d = allred_q;
        else
            allred_d = allred_q + 1'b1;
        ar_fault = int'(allred_d) > MAX_ALLRED;

        // lowest code wins; strict compare keeps the lowest direction on ties
        vcode = '0;
        vdir  = '0;
        for (int unsigned d = 0; d < 4; d++) begin
            if (dcode[d] != 3'd0 && (vcode == 3'd0 || dcode[d] < vcode)) begin
                vcode = dcode[d];
                vdir  = 2'(d);
            end
        end
        if (nonred_cnt > 3'd1 && (vcode == 3'd0 || vcode > 3'd2)) begin
            vcode = 3'd2;
            vdir  = '0;
        end
        if (ar_fault && vcode == 3'd0) begin
            vcode = 3'd6;
            vdir  = '0;
        end

        valid_d      = all_legal && (nonred_cnt == 3'd1);
        active_dir_d = valid_d ? act_idx : active_dir;
        phase_d      = phase_cnt + 8'(yr_cnt);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned d = 0; d < 4; d++) begin
                prev_q[d]  <= RED;
                dwell_q[d] <= CNT_W'(1);
            end
            allred_q     <= '0;
            fault        <= 1'b0;
            fault_code   <= '0;
            fault_dir    <= '0;
            active_dir   <= '0;
            active_valid <= 1'b0;
            phase_cnt    <= '0;
        end else begin
            for (int unsigned d = 0; d < 4; d++) begin
                prev_q[d]  <= prev_d[d];
                dwell_q[d] <= dwell_d[d];
            end
            allred_q     <= allred_d;
            active_dir   <= active_dir_d;
            active_valid <= valid_d;
            phase_cnt    <= phase_d;
            if (vcode != 3'd0) begin
                if (!fault || clear) begin
                    fault      <= 1'b1;
                    fault_code <= vcode;
                    fault_dir  <= vdir;
                end
            end else if (clear) begin
                fault      <= 1'b0;
                fault_code <= '0;
                fault_dir  <= '0;
            end
        end
    end

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Independent conflict monitor on the consuming side of the traffic controller's four light buses. It samples the north, south, east and west 3-bit light outputs every clock and checks each one for legal encoding, legal colour sequence and minimum dwell times. It also checks for cross-direction conflicts and for all-red stalls. The first violation is latched as a sticky fault with a code and a direction for the supervisor to read and clear.

## Interface
- MIN_GREEN, 3: minimum consecutive green samples before green->yellow.
- MIN_YELLOW, 2: minimum consecutive yellow samples before yellow->red.
- MAX_ALLRED, 4: maximum consecutive all-red samples tolerated.
- CNT_W, 8: width of the per-direction dwell counters and the all-red counter; counters saturate at 2^CNT_W-1.
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- north  input  3  north light bus: bit2 red, bit1 yellow, bit0 green.
- south  input  3  south light bus, same encoding.
- east  input  3  east light bus, same encoding.
- west  input  3  west light bus, same encoding.
- clear  input  1  one-cycle pulse that releases a latched fault.
- fault  output  1  sticky fault flag.
- fault_code  output  3  code of the latched fault (0 = none).
- fault_dir  output  2  direction of the latched fault: N=0, S=1, E=2, W=3.
- active_dir  output  2  index of the single non-red direction.
- active_valid  output  1  exactly one direction non-red and all encodings legal.
- phase_cnt  output  8  count of completed yellow->red transitions, wraps 255->0.

## Operation
- Legal values per bus: 100 (red), 010 (yellow), 001 (green). Every other value, including 000, is illegal.
- Per-direction state is the previous sampled colour plus a dwell counter. The counter holds the number of consecutive samples of that colour, including the current one.
- Allowed per-direction transitions: hold, red->green, green->yellow, yellow->red. All others are sequence faults.
- Fault codes:
  - 1: illegal encoding.
  - 2: conflict, meaning more than one direction non-red in the same sample.
  - 3: illegal transition.
  - 4: green->yellow with green dwell < MIN_GREEN.
  - 5: yellow->red with yellow dwell < MIN_YELLOW.
  - 6: all four red for more than MAX_ALLRED consecutive samples.
- Fault direction reporting:
  - Codes 2 and 6 report fault_dir=0.
  - Conflict is flagged on the sample where it first occurs.
- Simultaneous violations: lowest code wins; within a code, lowest direction index wins.
- An illegal-encoded bus:
  - does not update that direction's previous colour or dwell;
  - is excluded from the conflict check in that sample.
- Latching:
  - Fault latches on the first violation.
  - While fault=1, checking and tracking continue, but fault_code and fault_dir hold.
- Clear:
  - clear=1 with no violation in that sample: fault, fault_code and fault_dir go to 0.
  - clear=1 and a violation in the same sample: the new violation is latched (new fault wins).
- Tracking outputs:
  - active_dir holds its last value when active_valid=0.
  - phase_cnt increments once per yellow->red transition per direction. It counts a transition even when that transition faults with code 5.
- All-red counter:
  - counts consecutive all-red samples;
  - resets to 0 on any sample that is not all red;
  - saturates at its maximum.

## Timing
- All outputs are registered. A violation sampled at edge k is visible on fault, fault_code and fault_dir after edge k, i.e. one cycle of latency. active_dir, active_valid and phase_cnt have the same latency.
- Values while reset is low:
  - previous colour = red for all directions;
  - dwell = 1;
  - all-red counter = 0;
  - fault = 0, fault_code = 0, fault_dir = 0;
  - active_dir = 0, active_valid = 0, phase_cnt = 0.
- The first sample after reset is therefore checked against red; red->green is legal.
- Reset asserted mid-operation clears everything immediately, independent of the clock, including a latched fault.
- Dwell on transition:
  - The counter reloads to 1 for the new colour.
  - The minimum checks use the pre-transition count.
  - Saturated counts compare as large, so they never fault.

## Test plan
- Legal cycle check:
  - Stimulus: after reset, north green 3 samples, then yellow 2, then red; then east green 3, then yellow 2, then red. Other directions red throughout, and no all-red gap longer than 4 samples.
  - Required response: fault=0 throughout; phase_cnt=2; active_dir=0 then 2 with active_valid=1 during the non-red samples.
- Conflict check:
  - Stimulus: north=001 and south=001 in the same sample.
  - Required response: next cycle fault=1, fault_code=2, fault_dir=0.
- Short dwell check:
  - Stimulus: west green for 2 samples, then yellow.
  - Required response: fault_code=4, fault_dir=3.
  - Follow-up: clear, then yellow for 1 sample, then red gives fault_code=5, fault_dir=3, and phase_cnt increments.
- Encoding and priority check:
  - Stimulus: east=011 and north green->red in the same sample.
  - Required response: fault_code=1, fault_dir=2, since code 1 beats code 3.
  - Follow-up: later violations leave fault_code at 1 until clear.
- All-red watchdog and clear race:
  - Stimulus: all red for 5 samples.
  - Required response: fault_code=6 after the 5th sample.
  - Follow-up: clear pulsed on a sample with north 001->100 gives fault_code=3, fault_dir=0 (new fault wins).
- Async reset check:
  - Stimulus: with fault latched and phase_cnt=7, drive reset low between clock edges.
  - Required response: all outputs go to 0 without waiting for a clock edge. After release, north green is accepted as legal.
